// File: rtl/hdmi_sched_pkg.sv
// Shared types and widths for the HDMI frame-buffer read scheduler.
package hdmi_sched_pkg;
  localparam int FPIX_W = 22;
  localparam int LEN_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CHECK,
    S_REQ,
    S_BUSY,
    S_SETTLE
  } state_e;
endpackage

// File: rtl/hdmi_fb_rd_sched_vs_edge_det.sv
// Registered frame-start detector: one-cycle pulse on the edge of vs into its active level.
module vs_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vs,
  output logic fs
);
  logic vs_q, vs_d;
  logic fs_q, fs_d;

  always_comb begin
    vs_d = vs;
    fs_d = (vs == VS_POL) && (vs_q != VS_POL);
  end

  // vs_q resets to the active level so a sync already active at reset is not a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= VS_POL;
      fs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
      fs_q <= fs_d;
    end
  end

  assign fs = fs_q;
endmodule

// File: rtl/hdmi_fb_rd_sched.sv
// Frame-buffer burst read scheduler: keeps the pixel FIFO topped up and restarts
// the read pointer and FIFO at each frame start.
module hdmi_fb_rd_sched
  import hdmi_sched_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 24,
  parameter int unsigned       BURST_LEN  = 64,
  parameter int unsigned       FIFO_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter bit                VS_POL     = 1'b1
) (
  input  logic              pixel_clk,
  input  logic              sys_rst_n,
  input  logic              video_vs,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic [10:0]       fifo_wr_cnt,
  input  logic              fifo_empty,
  input  logic              data_req,
  output logic              fifo_clr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              underflow,
  output logic [7:0]        frame_cnt
);
  logic fs;

  state_e              state_q, state_d;
  logic [FPIX_W-1:0]   issued_q, issued_d;
  logic [FPIX_W-1:0]   frame_pix_q, frame_pix_d;
  logic                pend_q, pend_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                underflow_q, underflow_d;
  logic                fifo_clr_q, fifo_clr_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]    rd_len_q, rd_len_d;

  logic [FPIX_W-1:0]   remain;
  logic [LEN_W-1:0]    len_cur;
  logic                fits;

  vs_edge_det #(.VS_POL(VS_POL)) u_vs_edge (
    .clk   (pixel_clk),
    .rst_n (sys_rst_n),
    .vs    (video_vs),
    .fs    (fs)
  );

  // Length of the next burst and whether the FIFO has room for all of it
  always_comb begin
    remain = frame_pix_q - issued_q;
    if (remain > FPIX_W'(BURST_LEN)) len_cur = LEN_W'(BURST_LEN);
    else                             len_cur = remain[LEN_W-1:0];
    fits = (32'(fifo_wr_cnt) + 32'(len_cur)) <= FIFO_DEPTH;
  end

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    frame_pix_d = frame_pix_q;
    pend_d      = pend_q;
    frame_cnt_d = frame_cnt_q;
    underflow_d = underflow_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;

    if (fs) frame_pix_d = FPIX_W'(h_disp) * FPIX_W'(v_disp);
    if (data_req && fifo_empty && (state_q != S_IDLE)) underflow_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (fs) state_d = S_CLEAR;
      S_CLEAR: begin
        issued_d    = '0;
        frame_cnt_d = frame_cnt_q + 8'd1;
        pend_d      = 1'b0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (fs)                                     state_d = S_CLEAR;
        else if ((issued_q != frame_pix_q) && fits) state_d = S_REQ;
      end
      // A frame start during an outstanding burst is deferred until the burst lands
      S_REQ: begin
        if (fs) pend_d = 1'b1;
        if (rd_ack) begin
          issued_d = issued_q + FPIX_W'(rd_len_q);
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fs) pend_d = 1'b1;
        if (rd_done) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (pend_q || fs) begin
          state_d = S_CLEAR;
          pend_d  = 1'b0;
        end else begin
          state_d = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Address and length are captured once on entry to REQ and held until the ack
    if ((state_d == S_REQ) && (state_q != S_REQ)) begin
      rd_addr_d = FRAME_BASE + ADDR_W'(issued_q);
      rd_len_d  = len_cur;
    end

    fifo_clr_d = (state_d == S_CLEAR);
    rd_req_d   = (state_d == S_REQ);
  end

  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      issued_q    <= '0;
      frame_pix_q <= '0;
      pend_q      <= 1'b0;
      frame_cnt_q <= '0;
      underflow_q <= 1'b0;
      fifo_clr_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= FRAME_BASE;
      rd_len_q    <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      frame_pix_q <= frame_pix_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      underflow_q <= underflow_d;
      fifo_clr_q  <= fifo_clr_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
    end
  end

  assign fifo_clr  = fifo_clr_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign underflow = underflow_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: doc/hdmi_fb_rd_sched.md
# hdmi_fb_rd_sched

Frame-buffer read scheduler for the HDMI output path. It runs in the pixel clock domain and watches the video timing frame sync. It issues burst read requests to the memory controller so the pixel FIFO feeding the video driver's `data_in`/`data_req` port never runs dry. It also restarts the read pointer and clears the FIFO at every frame start.

## Interface
Parameters:
- `ADDR_W`, 24: memory address width, in 16-bit pixel units.
- `BURST_LEN`, 64: maximum pixels per read burst; must be ≥1.
- `FIFO_DEPTH`, 1024: capacity of the pixel FIFO in pixels.
- `FRAME_BASE`, 0: pixel address of the first pixel of the frame.
- `VS_POL`, 1: active level of `video_vs`; frame start is the edge into the active level.

Ports:
- `pixel_clk`, in, 1: the single clock.
- `sys_rst_n`, in, 1: reset, asynchronous and active-low.
- `video_vs`, in, 1: frame sync from the video driver.
- `h_disp`, in, 11: active pixels per line.
- `v_disp`, in, 11: active lines per frame.
- `fifo_wr_cnt`, in, 11: current pixel FIFO fill level.
- `fifo_empty`, in, 1: pixel FIFO empty flag.
- `data_req`, in, 1: pixel read strobe from the video driver.
- `fifo_clr`, out, 1: one-cycle synchronous clear to the pixel FIFO.
- `rd_req`, out, 1: burst request to the memory controller.
- `rd_addr`, out, ADDR_W: burst start address.
- `rd_len`, out, 8: burst length in pixels, range 1..BURST_LEN.
- `rd_ack`, in, 1: memory controller accepts the request.
- `rd_done`, in, 1: last pixel of the accepted burst has been written to the FIFO.
- `underflow`, out, 1: sticky flag; cleared only by reset.
- `frame_cnt`, out, 8: frames started, wraps at 255→0.

## Operation
- Frame start (`fs`) is detected from a one-cycle delayed copy of `video_vs`: `fs = (vs == VS_POL) && (vs_d != VS_POL)`.
- `frame_pix = h_disp * v_disp`, 22 bits, latched at each `fs`. `h_disp`/`v_disp` changes take effect only at the next frame.
- The `issued` counter is 22 bits and holds pixels requested in the current frame.
- `rd_addr = FRAME_BASE + issued`, truncated to ADDR_W, so the address wraps modulo 2^ADDR_W.
- `rd_len = min(BURST_LEN, frame_pix - issued)`.
- FSM states:
  - IDLE: entered from reset. Ignores everything except `fs`. On `fs`, go to CLEAR.
  - CLEAR: `fifo_clr=1` for one cycle, `issued=0`, `frame_cnt` += 1, then go to CHECK.
  - CHECK: if `issued == frame_pix`, stay in CHECK (frame fully fetched). Else if `fifo_wr_cnt + rd_len <= FIFO_DEPTH`, go to REQ. Else stay in CHECK.
  - REQ: `rd_req=1`, with `rd_addr` and `rd_len` held stable until the cycle `rd_ack=1`. In that cycle, `issued += rd_len` and the FSM goes to BUSY.
  - BUSY: wait for `rd_done`, then go to SETTLE.
  - SETTLE: one idle cycle so `fifo_wr_cnt` reflects the completed burst, then go to CHECK. If `pend` is set, go to CLEAR instead and clear `pend`.
- `fs` in CHECK or SETTLE: go to CLEAR on the next cycle. A request never started is simply dropped.
- `fs` in REQ or BUSY: set `pend`. The request is never withdrawn, and the outstanding burst completes normally. `fifo_clr` is issued only after `rd_done`, so stale pixels from that burst are flushed.
- A second `fs` while `pend` is already set is absorbed; `frame_cnt` counts only CLEAR entries.
- `underflow` sets on any cycle with `data_req=1 && fifo_empty=1` outside IDLE.
- `frame_pix == 0`: CHECK never requests.

## Timing
- Reset values:
  - `fifo_clr=0`, `rd_req=0`, `rd_addr=FRAME_BASE`, `rd_len=0`.
  - `underflow=0`, `frame_cnt=0`, `pend=0`.
  - State is IDLE, `issued=0`.
- `video_vs` edge → `fifo_clr` high: 2 cycles (edge-detect register, then CLEAR).
- CLEAR → first `rd_req` with FIFO space available: 2 cycles (CHECK, REQ).
- `rd_ack` may arrive in the same cycle `rd_req` rises. `rd_req` drops the cycle after the ack.
- `rd_done` → next `rd_req`: 3 cycles minimum (SETTLE, CHECK, REQ).
- All outputs are registered; no combinational input-to-output path.
- Asserting reset mid-burst abandons the burst. The memory controller must be reset by the same `sys_rst_n`.

## Structure
- Shared package `hdmi_sched_pkg` holds:
  - The state enum (IDLE, CLEAR, CHECK, REQ, BUSY, SETTLE).
  - The `frame_pix` width constant (22).
  - The `rd_len` width constant (8).
- One sub-module, `vs_edge_det`: the registered polarity-aware edge detector producing `fs`.
- The scheduler FSM, counters and arithmetic live in the top module.

## Test plan
- Reset, then `h_disp=8`, `v_disp=2`, `BURST_LEN=4`, `FIFO_DEPTH=16`, FIFO level 0, immediate ack:
  - Required: `fifo_clr` pulses once.
  - Required: exactly 4 requests, addr 0/4/8/12, len 4.
  - Required: `frame_cnt=1`.
- `h_disp=10`, `v_disp=1`, `BURST_LEN=4`:
  - Required: lengths 4, 4, 2; no fourth request.
- `fifo_wr_cnt=14`, `FIFO_DEPTH=16`, `BURST_LEN=4`:
  - Required: no `rd_req` while the level stays 14.
  - Drop the level to 12 → `rd_req` rises within 2 cycles.
- `fs` asserted during BUSY:
  - Required: `fifo_clr` occurs only after `rd_done` plus SETTLE.
  - Required: next request addr = `FRAME_BASE`, and `frame_cnt` increments once.
- `rd_ack` delayed 5 cycles:
  - Required: `rd_req`, `rd_addr` and `rd_len` stay constant across all 5 cycles.
  - Required: `issued` advances exactly once.
- `data_req=1` with `fifo_empty=1` after the first frame start:
  - Required: `underflow` goes high and stays high until `sys_rst_n` is asserted low.
  - Required: with `FRAME_BASE=2^24-2`, `rd_addr` wraps to 2 on the second burst.
